// File: rtl/sdram_arbit.sv
// sdram_arbit: sequences init, auto-refresh, write and read sub-controllers onto the SDRAM pins.
// Optional macro RW_FAIR_EN: alternate write/read grants under contention instead of fixed write priority.
module sdram_arbit #(
  parameter logic [9:0] MAX_GRANT_CLK = 10'd1023,
  parameter logic [3:0] NOP           = 4'b0111
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [11:0] init_addr,
  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_ba,
  input  logic [11:0] aref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [11:0] wr_addr,
  input  logic        wr_sdram_en,
  input  logic [15:0] wr_sdram_data,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [11:0] rd_addr,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_addr,
  output logic        sdram_dq_oe,
  output logic [15:0] sdram_dq_out,
  output logic        err_timeout
);

  typedef enum logic [2:0] {IDLE, ARBIT, AREF, WRITE, READ} state_t;

  state_t      state_q, state_d;
  logic [9:0]  grant_cnt_q, grant_cnt_d;
  logic        aref_en_q, aref_en_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic        err_timeout_q, err_timeout_d;
  logic        grant_end;
  logic [3:0]  pin_cmd;
`ifdef RW_FAIR_EN
  logic        last_wr_q, last_wr_d;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      grant_cnt_q   <= '0;
      aref_en_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      err_timeout_q <= 1'b0;
`ifdef RW_FAIR_EN
      last_wr_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_cnt_q   <= grant_cnt_d;
      aref_en_q     <= aref_en_d;
      wr_en_q       <= wr_en_d;
      rd_en_q       <= rd_en_d;
      err_timeout_q <= err_timeout_d;
`ifdef RW_FAIR_EN
      last_wr_q     <= last_wr_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_cnt_d   = grant_cnt_q;
    err_timeout_d = err_timeout_q;
    grant_end     = 1'b0;
    case (state_q)
      AREF:    grant_end = aref_end;
      WRITE:   grant_end = wr_end;
      READ:    grant_end = rd_end;
      default: grant_end = 1'b0;
    endcase

    case (state_q)
      IDLE: begin
        grant_cnt_d = '0;
        if (init_end) state_d = ARBIT;
      end
      ARBIT: begin
        grant_cnt_d = '0;
        if (aref_req) state_d = AREF;
`ifdef RW_FAIR_EN
        else if (wr_req && rd_req) state_d = last_wr_q ? READ : WRITE;
`endif
        else if (wr_req) state_d = WRITE;
        else if (rd_req) state_d = READ;
      end
      default: begin
        // A completion wins over a watchdog expiry landing on the same cycle.
        if (grant_end) begin
          state_d = ARBIT;
        end else if (grant_cnt_q == MAX_GRANT_CLK - 10'd1) begin
          state_d       = ARBIT;
          err_timeout_d = 1'b1;
        end else begin
          grant_cnt_d = grant_cnt_q + 10'd1;
        end
      end
    endcase

    aref_en_d = (state_d == AREF);
    wr_en_d   = (state_d == WRITE);
    rd_en_d   = (state_d == READ);
  end

`ifdef RW_FAIR_EN
  always_comb begin
    last_wr_d = last_wr_q;
    if (state_q == ARBIT && state_d == WRITE) last_wr_d = 1'b1;
    if (state_q == ARBIT && state_d == READ)  last_wr_d = 1'b0;
  end
`endif

  always_comb begin
    pin_cmd      = NOP;
    sdram_ba     = 2'b11;
    sdram_addr   = 12'hfff;
    sdram_dq_oe  = 1'b0;
    sdram_dq_out = 16'd0;
    case (state_q)
      IDLE: begin
        pin_cmd    = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      AREF: begin
        pin_cmd    = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      WRITE: begin
        pin_cmd      = wr_cmd;
        sdram_ba     = wr_ba;
        sdram_addr   = wr_addr;
        sdram_dq_oe  = wr_sdram_en;
        sdram_dq_out = wr_sdram_data;
      end
      READ: begin
        pin_cmd    = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pin_cmd;
  assign sdram_cke   = 1'b1;
  assign aref_en     = aref_en_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed scenarios plus randomized traffic for sdram_arbit, checked
// cycle by cycle against a grant-ownership reference model (watchdog shortened to 16).
module tb_sdram_arbit;

  localparam int MAXG = 16;
`ifdef RW_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        init_end;
  logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [1:0]  init_ba, aref_ba, wr_ba, rd_ba;
  logic [11:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic        aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic        wr_sdram_en;
  logic [15:0] wr_sdram_data;
  logic        aref_en, wr_en, rd_en, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [11:0] sdram_addr;
  logic        sdram_dq_oe;
  logic [15:0] sdram_dq_out;
  logic        err_timeout;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Reference model: who owns the bus (0 none, 1 refresh, 2 write, 3 read) and for how long.
  bit m_idle;
  int m_owner;
  int m_age;
  bit m_err;
  bit m_last_wr;

  sdram_arbit #(.MAX_GRANT_CLK(10'(MAXG))) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
    .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end),
    .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end),
    .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end),
    .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_oe(sdram_dq_oe), .sdram_dq_out(sdram_dq_out),
    .err_timeout(err_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkPins();
    logic [17:0] exp_pins;
    logic [16:0] exp_dq;
    if (m_idle) exp_pins = {init_cmd, init_ba, init_addr};
    else begin
      case (m_owner)
        1:       exp_pins = {aref_cmd, aref_ba, aref_addr};
        2:       exp_pins = {wr_cmd, wr_ba, wr_addr};
        3:       exp_pins = {rd_cmd, rd_ba, rd_addr};
        default: exp_pins = {4'b0111, 2'b11, 12'hfff};
      endcase
    end
    exp_dq = (!m_idle && m_owner == 2) ? {wr_sdram_en, wr_sdram_data} : 17'd0;
    checkOutput("pins", {14'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr},
                {14'd0, exp_pins});
    checkOutput("dq", {15'd0, sdram_dq_oe, sdram_dq_out}, {15'd0, exp_dq});
    checkOutput("cke", {31'd0, sdram_cke}, 32'd1);
  endtask

  task automatic checkRegs();
    logic [2:0] exp_g;
    exp_g = m_idle ? 3'b000 : {m_owner == 1, m_owner == 2, m_owner == 3};
    checkOutput("grants", {29'd0, aref_en, wr_en, rd_en}, {29'd0, exp_g});
    checkOutput("err_timeout", {31'd0, err_timeout}, {31'd0, m_err});
  endtask

  // One clock: randomize the sub-controller pin values, check the mux, advance model and DUT.
  task automatic applyStimulus();
    bit n_idle, n_err, n_last, done;
    int n_owner, n_age;
    init_cmd = 4'($urandom);  init_ba = 2'($urandom);  init_addr = 12'($urandom);
    aref_cmd = 4'($urandom);  aref_ba = 2'($urandom);  aref_addr = 12'($urandom);
    wr_cmd   = 4'($urandom);  wr_ba   = 2'($urandom);  wr_addr   = 12'($urandom);
    rd_cmd   = 4'($urandom);  rd_ba   = 2'($urandom);  rd_addr   = 12'($urandom);
    #1;
    checkPins();
    n_idle = m_idle; n_owner = m_owner; n_age = m_age; n_err = m_err; n_last = m_last_wr;
    if (sys_rst) begin
      n_idle = 1; n_owner = 0; n_age = 0; n_err = 0; n_last = 0;
    end else if (m_idle) begin
      if (init_end) n_idle = 0;
    end else if (m_owner == 0) begin
      n_age = 0;
      if (aref_req) n_owner = 1;
      else if (wr_req && rd_req) n_owner = (FAIR && m_last_wr) ? 3 : 2;
      else if (wr_req) n_owner = 2;
      else if (rd_req) n_owner = 3;
      if (n_owner == 2) n_last = 1;
      if (n_owner == 3) n_last = 0;
    end else begin
      done = (m_owner == 1 && aref_end) || (m_owner == 2 && wr_end) || (m_owner == 3 && rd_end);
      if (done) n_owner = 0;
      else if (m_age == MAXG - 1) begin
        n_owner = 0;
        n_err = 1;
      end else n_age = m_age + 1;
    end
    @(posedge sys_clk);
    #1;
    m_idle = n_idle; m_owner = n_owner; m_age = n_age; m_err = n_err; m_last_wr = n_last;
    checkRegs();
  endtask

  function automatic int dutOwner();
    if (aref_en) return 1;
    if (wr_en) return 2;
    if (rd_en) return 3;
    return 0;
  endfunction

  // Wait (bounded) for a grant, hold it a few cycles, then pulse the matching end.
  task automatic runGrant(input bit drop_req, output int who);
    for (int i = 0; i < 20; i++) begin
      if (dutOwner() != 0) break;
      applyStimulus();
    end
    who = dutOwner();
    if (who == 0) begin
      checkOutput("grant_wait_expired", 32'd0, 32'd1);
      return;
    end
    repeat (3) applyStimulus();
    case (who)
      1: begin aref_end = 1; if (drop_req) aref_req = 0; end
      2: begin wr_end = 1;   if (drop_req) wr_req = 0;   end
      default: begin rd_end = 1; if (drop_req) rd_req = 0; end
    endcase
    applyStimulus();
    aref_end = 0; wr_end = 0; rd_end = 0;
  endtask

  initial begin
    int who, cnt;
    sys_rst = 1; init_end = 0;
    aref_req = 0; aref_end = 0; wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
    wr_sdram_en = 0; wr_sdram_data = 16'd0;
    init_cmd = '0; init_ba = '0; init_addr = '0; aref_cmd = '0; aref_ba = '0; aref_addr = '0;
    wr_cmd = '0; wr_ba = '0; wr_addr = '0; rd_cmd = '0; rd_ba = '0; rd_addr = '0;
    m_idle = 1; m_owner = 0; m_age = 0; m_err = 0; m_last_wr = 0;
    @(posedge sys_clk);
    #1;
    checkRegs();
    applyStimulus();

    // Traffic held off until init completes.
    sys_rst = 0; wr_req = 1;
    repeat (200) applyStimulus();
    checkOutput("t1_no_grant", {31'd0, wr_en}, 32'd0);
    init_end = 1;
    applyStimulus();
    checkOutput("t1_arbit_no_grant", {31'd0, wr_en}, 32'd0);
    applyStimulus();
    checkOutput("t1_wr_en", {31'd0, wr_en}, 32'd1);
    wr_end = 1; wr_req = 0;
    applyStimulus();
    wr_end = 0;

    // Fixed priority refresh > write > read.
    aref_req = 1; wr_req = 1; rd_req = 1;
    runGrant(1, who); checkOutput("t2_first", who, 32'd1);
    runGrant(1, who); checkOutput("t2_second", who, 32'd2);
    runGrant(1, who); checkOutput("t2_third", who, 32'd3);

    // Write data drive and the ARBIT idle pattern.
    wr_req = 1; wr_sdram_en = 1; wr_sdram_data = 16'hA5A5;
    applyStimulus();
    checkOutput("t3_wr_en", {31'd0, wr_en}, 32'd1);
    checkOutput("t3_dq_oe", {31'd0, sdram_dq_oe}, 32'd1);
    checkOutput("t3_dq_out", {16'd0, sdram_dq_out}, 32'h0000A5A5);
    wr_end = 1; wr_req = 0;
    applyStimulus();
    wr_end = 0;
    checkOutput("t3_arbit_dq_oe", {31'd0, sdram_dq_oe}, 32'd0);
    checkOutput("t3_arbit_cmd", {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, 32'h7);

    // Watchdog on a read that never completes.
    rd_req = 1;
    applyStimulus();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!rd_en) break;
      cnt++;
      applyStimulus();
    end
    checkOutput("t4_grant_cycles", cnt, 32'(MAXG));
    checkOutput("t4_err_set", {31'd0, err_timeout}, 32'd1);
    rd_req = 0;
    repeat (3) applyStimulus();
    rd_end = 1;
    applyStimulus();
    rd_end = 0;
    repeat (3) applyStimulus();
    checkOutput("t4_err_sticky", {31'd0, err_timeout}, 32'd1);

    // Reset in the middle of a write grant.
    wr_req = 1;
    applyStimulus();
    applyStimulus();
    checkOutput("t5_pre_wr_en", {31'd0, wr_en}, 32'd1);
    sys_rst = 1; wr_req = 0;
    applyStimulus();
    sys_rst = 0;
    checkOutput("t5_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("t5_err", {31'd0, err_timeout}, 32'd0);
    applyStimulus();

    // Write/read contention.
    wr_req = 1; rd_req = 1;
    for (int g = 0; g < 4; g++) begin
      runGrant(0, who);
      checkOutput($sformatf("t6_grant%0d", g), who, (FAIR && (g % 2 == 1)) ? 32'd3 : 32'd2);
    end
    wr_req = 0; rd_req = 0;

    // Randomized traffic including stray ends, init_end drops and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      sys_rst       = ($urandom_range(149) == 0);
      init_end      = ($urandom_range(7) != 0);
      aref_req      = ($urandom_range(7) == 0);
      wr_req        = ($urandom_range(2) == 0);
      rd_req        = ($urandom_range(2) == 0);
      aref_end      = ($urandom_range(5) == 0);
      wr_end        = ($urandom_range(5) == 0);
      rd_end        = ($urandom_range(5) == 0);
      wr_sdram_en   = 1'($urandom);
      wr_sdram_data = 16'($urandom);
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
